// File: rtl/mor1kx_tlb_reload_arbiter_pkg.sv
// rtl/mor1kx_tlb_reload_arbiter_pkg.sv - shared types and constants for the TLB reload arbiter
package mor1kx_tlb_reload_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BEAT = 2'd1,
      ST_GAP  = 2'd2
   } arb_state_t;

   localparam logic WALKER_DMMU = 1'b0;
   localparam logic WALKER_IMMU = 1'b1;

   // A disabled watchdog still needs a one-bit timer to keep the declaration legal.
   function automatic int timer_width(input int limit);
      return (limit > 0) ? $clog2(limit + 1) : 1;
   endfunction

endpackage

// File: rtl/mor1kx_tlb_reload_arbiter_rr_pick2.sv
// rtl/mor1kx_tlb_reload_arbiter_rr_pick2.sv - two-way round-robin picker, ties go to the walker not served last
module mor1kx_rr_pick2
   import mor1kx_tlb_reload_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic       valid,
   output logic       winner
);

   always_comb begin
      valid = |req;
      if (&req)
         winner = ~last_grant;
      else if (req[WALKER_IMMU])
         winner = WALKER_IMMU;
      else
         winner = WALKER_DMMU;
   end

endmodule

// File: rtl/mor1kx_tlb_reload_arbiter.sv
// rtl/mor1kx_tlb_reload_arbiter.sv - shares one single-beat read port between the DMMU and IMMU reload walkers
module mor1kx_tlb_reload_arbiter
   import mor1kx_tlb_reload_arbiter_pkg::*;
#(
   parameter int OPTION_OPERAND_WIDTH = 32,
   parameter int TIMEOUT_CYCLES       = 255
)
(
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            dmmu_req_i,
   input  logic [OPTION_OPERAND_WIDTH-1:0] dmmu_addr_i,
   output logic                            dmmu_ack_o,
   output logic                            dmmu_err_o,
   input  logic                            immu_req_i,
   input  logic [OPTION_OPERAND_WIDTH-1:0] immu_addr_i,
   output logic                            immu_ack_o,
   output logic                            immu_err_o,
   output logic [OPTION_OPERAND_WIDTH-1:0] reload_data_o,
   output logic                            bus_req_o,
   output logic [OPTION_OPERAND_WIDTH-1:0] bus_adr_o,
   input  logic                            bus_ack_i,
   input  logic                            bus_err_i,
   input  logic [OPTION_OPERAND_WIDTH-1:0] bus_dat_i,
   output logic                            busy_o
);

   localparam int TW = timer_width(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TIMER_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   arb_state_t                      state;
   arb_state_t                      state_nxt;
   logic                            grant;
   logic                            last_grant;
   logic [TW-1:0]                   timer;
   logic                            pick_valid;
   logic                            pick_winner;
   logic                            granted_req;
   logic                            timeout;
   logic                            beat_ok;
   logic                            beat_fail;
   logic                            beat_end;
   logic [OPTION_OPERAND_WIDTH-1:0] granted_addr;
   logic [OPTION_OPERAND_WIDTH-1:0] winner_addr;

   mor1kx_rr_pick2 u_pick (
      .req        ({immu_req_i, dmmu_req_i}),
      .last_grant (last_grant),
      .valid      (pick_valid),
      .winner     (pick_winner)
   );

   assign granted_req  = (grant == WALKER_IMMU) ? immu_req_i  : dmmu_req_i;
   assign granted_addr = (grant == WALKER_IMMU) ? immu_addr_i : dmmu_addr_i;
   assign winner_addr  = (pick_winner == WALKER_IMMU) ? immu_addr_i : dmmu_addr_i;

   // An ack arriving on the watchdog's last cycle still counts as success; err beats ack.
   assign timeout   = (TIMEOUT_CYCLES != 0) && (timer == TIMER_LAST);
   assign beat_ok   = bus_ack_i && !bus_err_i;
   assign beat_fail = bus_err_i || (timeout && !bus_ack_i);
   assign beat_end  = bus_ack_i || bus_err_i || timeout;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (pick_valid) state_nxt = ST_BEAT;
         ST_BEAT: if (beat_end) state_nxt = (granted_req && beat_ok) ? ST_GAP : ST_IDLE;
         ST_GAP:  state_nxt = granted_req ? ST_BEAT : ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // An aborted walk gets no completion pulse even though its beat finishes on the bus.
   always_comb begin
      dmmu_ack_o = 1'b0;
      dmmu_err_o = 1'b0;
      immu_ack_o = 1'b0;
      immu_err_o = 1'b0;
      if (state == ST_BEAT && granted_req) begin
         if (grant == WALKER_IMMU) begin
            immu_ack_o = beat_ok;
            immu_err_o = beat_fail;
         end else begin
            dmmu_ack_o = beat_ok;
            dmmu_err_o = beat_fail;
         end
      end
   end

   assign busy_o        = (state != ST_IDLE);
   assign reload_data_o = bus_dat_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant      <= WALKER_DMMU;
         last_grant <= WALKER_IMMU;
         timer      <= '0;
         bus_req_o  <= 1'b0;
         bus_adr_o  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pick_valid) begin
                  grant     <= pick_winner;
                  bus_adr_o <= winner_addr;
                  bus_req_o <= 1'b1;
                  timer     <= '0;
               end
            end
            ST_BEAT: begin
               if (TIMEOUT_CYCLES != 0)
                  timer <= timer + 1'b1;
               if (beat_end)
                  bus_req_o <= 1'b0;
            end
            ST_GAP: begin
               if (granted_req) begin
                  bus_adr_o <= granted_addr;
                  bus_req_o <= 1'b1;
                  timer     <= '0;
               end
            end
            default: ;
         endcase
         if (state != ST_IDLE && state_nxt == ST_IDLE)
            last_grant <= grant;
      end
   end

endmodule

// File: tb/tb_mor1kx_tlb_reload_arbiter.sv
// tb/tb_mor1kx_tlb_reload_arbiter.sv - self-checking bench for the TLB reload arbiter
module tb_mor1kx_tlb_reload_arbiter;

   typedef struct packed {
      logic        w;
      logic        err;
      logic [31:0] dat;
   } ev_t;

   typedef struct packed {
      int          lat;
      logic        err;
      logic [31:0] dat;
   } beat_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        dmmu_req_i = 1'b0, immu_req_i = 1'b0;
   logic [31:0] dmmu_addr_i = '0, immu_addr_i = '0;
   logic        bus_ack_i = 1'b0, bus_err_i = 1'b0;
   logic [31:0] bus_dat_i = '0;
   logic        dmmu_ack_o, dmmu_err_o, immu_ack_o, immu_err_o, bus_req_o, busy_o;
   logic [31:0] reload_data_o, bus_adr_o;

   logic        nt_req = 1'b0;
   logic        nt_dack, nt_derr, nt_iack, nt_ierr, nt_bus_req, nt_busy;
   logic [31:0] nt_data, nt_adr;

   mor1kx_tlb_reload_arbiter #(.OPTION_OPERAND_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .dmmu_req_i(dmmu_req_i), .dmmu_addr_i(dmmu_addr_i), .dmmu_ack_o(dmmu_ack_o), .dmmu_err_o(dmmu_err_o),
      .immu_req_i(immu_req_i), .immu_addr_i(immu_addr_i), .immu_ack_o(immu_ack_o), .immu_err_o(immu_err_o),
      .reload_data_o(reload_data_o), .bus_req_o(bus_req_o), .bus_adr_o(bus_adr_o),
      .bus_ack_i(bus_ack_i), .bus_err_i(bus_err_i), .bus_dat_i(bus_dat_i), .busy_o(busy_o)
   );

   mor1kx_tlb_reload_arbiter #(.OPTION_OPERAND_WIDTH(32), .TIMEOUT_CYCLES(0)) dut_nt (
      .clk(clk), .rst_n(rst_n),
      .dmmu_req_i(nt_req), .dmmu_addr_i(32'h0000_8000), .dmmu_ack_o(nt_dack), .dmmu_err_o(nt_derr),
      .immu_req_i(1'b0), .immu_addr_i(32'h0), .immu_ack_o(nt_iack), .immu_err_o(nt_ierr),
      .reload_data_o(nt_data), .bus_req_o(nt_bus_req), .bus_adr_o(nt_adr),
      .bus_ack_i(1'b0), .bus_err_i(1'b0), .bus_dat_i(32'h0), .busy_o(nt_busy)
   );

   int tests = 0, fails = 0, cyc = 0;
   logic        wk_req [2];
   logic [31:0] wk_addr [2];
   logic [31:0] q0 [$], q1 [$];
   beat_t       plan [$];
   int          h, cur_lat;
   logic        started, cur_err, nxt_ack, nxt_err;
   logic [31:0] nxt_dat, applied_dat;
   ev_t         obs_ev [$], exp_ev [$];
   logic [31:0] obs_adr [$], exp_adr [$];
   int          rise_q [$], fall_q [$], ack_cyc [$], err_cyc [$], idle_q [$];
   logic        prev_bus_req, prev_busy, prev_err, prev_ack;
   logic        last_w;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_obs();
      obs_ev.delete(); exp_ev.delete(); obs_adr.delete(); exp_adr.delete();
      rise_q.delete(); fall_q.delete(); ack_cyc.delete(); err_cyc.delete(); idle_q.delete();
   endtask

   task automatic reset_models();
      wk_req[0] = 1'b0; wk_req[1] = 1'b0; wk_addr[0] = '0; wk_addr[1] = '0;
      q0.delete(); q1.delete(); plan.delete();
      h = 0; started = 1'b0; cur_lat = 1; cur_err = 1'b0;
      nxt_ack = 1'b0; nxt_err = 1'b0; nxt_dat = '0; applied_dat = '0;
      prev_bus_req = 1'b0; prev_busy = 1'b0; prev_err = 1'b0; prev_ack = 1'b0;
      clear_obs();
   endtask

   task automatic walker_advance(input logic w, input logic failed);
      if (w == 1'b0) begin
         if (q0.size() > 0) void'(q0.pop_front());
         if (failed) q0.delete();
         if (q0.size() == 0) wk_req[0] = 1'b0; else wk_addr[0] = q0[0];
      end else begin
         if (q1.size() > 0) void'(q1.pop_front());
         if (failed) q1.delete();
         if (q1.size() == 0) wk_req[1] = 1'b0; else wk_addr[1] = q1[0];
      end
   endtask

   task automatic sample();
      logic a [2];
      logic e [2];
      beat_t b;
      a[0] = dmmu_ack_o; a[1] = immu_ack_o; e[0] = dmmu_err_o; e[1] = immu_err_o;
      if (prev_err) check("busy_after_err", busy_o, 0);
      if (prev_ack) check("gap_after_ack", {busy_o, bus_req_o}, 2'b10);
      for (int w = 0; w < 2; w++) begin
         if (a[w]) begin
            obs_ev.push_back('{w: w[0], err: 1'b0, dat: reload_data_o});
            ack_cyc.push_back(cyc);
            walker_advance(w[0], 1'b0);
         end
         if (e[w]) begin
            obs_ev.push_back('{w: w[0], err: 1'b1, dat: 32'h0});
            err_cyc.push_back(cyc);
            walker_advance(w[0], 1'b1);
         end
      end
      prev_err = e[0] | e[1];
      prev_ack = a[0] | a[1];
      if (bus_req_o && !prev_bus_req) begin obs_adr.push_back(bus_adr_o); rise_q.push_back(cyc); end
      if (!bus_req_o && prev_bus_req) fall_q.push_back(cyc);
      if (!busy_o && prev_busy) idle_q.push_back(cyc);
      prev_bus_req = bus_req_o;
      prev_busy = busy_o;
      // bus responder: ack or err cur_lat cycles into the beat
      if (bus_ack_i || bus_err_i) begin
         nxt_ack = 1'b0; nxt_err = 1'b0;
      end else if (!bus_req_o) begin
         h = 0; started = 1'b0; nxt_ack = 1'b0; nxt_err = 1'b0;
      end else begin
         if (!started) begin
            started = 1'b1;
            if (plan.size() > 0) begin
               b = plan.pop_front(); cur_lat = b.lat; cur_err = b.err; nxt_dat = b.dat;
            end else begin
               cur_lat = 1; cur_err = 1'b0; nxt_dat = $urandom;
            end
         end
         h++;
         if (h == cur_lat) begin nxt_ack = !cur_err; nxt_err = cur_err; end
      end
   endtask

   task automatic step();
      @(posedge clk); #1;
      dmmu_req_i = wk_req[0]; immu_req_i = wk_req[1];
      dmmu_addr_i = wk_addr[0]; immu_addr_i = wk_addr[1];
      bus_ack_i = nxt_ack; bus_err_i = nxt_err; bus_dat_i = nxt_dat; applied_dat = nxt_dat;
      @(negedge clk);
      cyc++;
      sample();
   endtask

   task automatic add_beat(input logic w, input logic [31:0] a, input int lat, input logic err,
                           input logic [31:0] d, input logic live);
      if (w == 1'b0) q0.push_back(a); else q1.push_back(a);
      if (live) begin
         exp_adr.push_back(a);
         plan.push_back('{lat: lat, err: err, dat: d});
         exp_ev.push_back('{w: w, err: err, dat: err ? 32'h0 : d});
      end
   endtask

   task automatic go(input logic w);
      wk_req[w] = 1'b1;
      wk_addr[w] = (w == 1'b0) ? q0[0] : q1[0];
   endtask

   task automatic run_until_idle(input string tag);
      int n = 0;
      do begin step(); n++; end
      while (!(wk_req[0] == 1'b0 && wk_req[1] == 1'b0 && !busy_o) && n < 300);
      check({tag, "_completes"}, n < 300, 1);
   endtask

   task automatic compare(input string tag);
      int ne, na;
      check({tag, "_event_count"}, obs_ev.size(), exp_ev.size());
      check({tag, "_addr_count"}, obs_adr.size(), exp_adr.size());
      ne = (obs_ev.size() < exp_ev.size()) ? obs_ev.size() : exp_ev.size();
      na = (obs_adr.size() < exp_adr.size()) ? obs_adr.size() : exp_adr.size();
      for (int i = 0; i < ne; i++) check({tag, "_event"}, 64'(obs_ev[i]), 64'(exp_ev[i]));
      for (int i = 0; i < na; i++) check({tag, "_bus_adr"}, obs_adr[i], exp_adr[i]);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      reset_models();
      step(); step();
      rst_n = 1'b1;
      last_w = 1'b1;
   endtask

   task automatic random_round(input int force_mask);
      int mask, cnt, n, ea;
      logic order [2];
      logic dead;
      logic [31:0] a, d;
      mask = (force_mask != 0) ? force_mask : int'($urandom_range(1, 3));
      if (mask == 3) begin order[0] = !last_w; order[1] = last_w; cnt = 2; end
      else begin order[0] = (mask == 2); order[1] = 1'b0; cnt = 1; end
      clear_obs();
      for (int i = 0; i < cnt; i++) begin
         n = $urandom_range(1, 3);
         ea = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
         dead = 1'b0;
         for (int k = 0; k < n; k++) begin
            a = $urandom & 32'hFFFF_FFFC;
            d = $urandom;
            add_beat(order[i], a, $urandom_range(1, 3), k == ea, d, !dead);
            if (k == ea) dead = 1'b1;
         end
      end
      last_w = order[cnt - 1];
      for (int i = 0; i < cnt; i++) go(order[i]);
      run_until_idle("round");
      compare("round");
   endtask

   initial begin
      int req_cyc, r, nt_high, nt_errs;
      last_w = 1'b1;
      reset_models();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_bus_req", bus_req_o, 0);
      check("reset_bus_adr", bus_adr_o, 0);
      check("reset_busy", busy_o, 0);
      check("reset_walker_outs", {dmmu_ack_o, dmmu_err_o, immu_ack_o, immu_err_o}, 0);
      rst_n = 1'b1;
      step();

      // DMMU-only two-beat walk with one-cycle bus latency
      clear_obs();
      add_beat(1'b0, 32'h0000_1000, 1, 1'b0, 32'h00A0_4001, 1'b1);
      add_beat(1'b0, 32'h0000_2004, 1, 1'b0, 32'h1234_5401, 1'b1);
      req_cyc = cyc + 1;
      go(1'b0);
      run_until_idle("dmmu_walk");
      compare("dmmu_walk");
      check("first_beat_latency", rise_q[0], req_cyc + 1);
      check("gap_one_cycle_fall", fall_q[0], ack_cyc[0] + 1);
      check("gap_one_cycle_rise", rise_q[1], ack_cyc[0] + 2);
      check("walk_release_cycle", idle_q[0], req_cyc + 7);

      // Tie out of reset: DMMU first, IMMU follows soon after release
      do_reset();
      clear_obs();
      add_beat(1'b0, 32'h0000_3000, 1, 1'b0, 32'hAAAA_0001, 1'b1);
      add_beat(1'b0, 32'h0000_3004, 1, 1'b0, 32'hAAAA_0002, 1'b1);
      add_beat(1'b1, 32'h0000_4000, 1, 1'b0, 32'hBBBB_0001, 1'b1);
      add_beat(1'b1, 32'h0000_4004, 1, 1'b0, 32'hBBBB_0002, 1'b1);
      go(1'b0); go(1'b1);
      run_until_idle("tie_reset");
      compare("tie_reset");
      check("immu_after_release", rise_q[2], ack_cyc[1] + 3);

      // Following tie goes to DMMU; its second beat errors, IMMU is served next
      clear_obs();
      add_beat(1'b0, 32'h0000_5000, 1, 1'b0, 32'hCCCC_0001, 1'b1);
      add_beat(1'b0, 32'h0000_5004, 2, 1'b1, 32'hCCCC_0002, 1'b1);
      add_beat(1'b1, 32'h0000_6000, 1, 1'b0, 32'hDDDD_0001, 1'b1);
      add_beat(1'b1, 32'h0000_6004, 3, 1'b0, 32'hDDDD_0002, 1'b1);
      go(1'b0); go(1'b1);
      run_until_idle("bus_err");
      compare("bus_err");
      check("immu_after_err", rise_q[2], err_cyc[0] + 2);
      last_w = 1'b1;

      // Watchdog: bus never answers
      clear_obs();
      add_beat(1'b0, 32'h0000_7000, 99, 1'b0, 32'h0, 1'b1);
      exp_ev.delete();
      exp_ev.push_back('{w: 1'b0, err: 1'b1, dat: 32'h0});
      go(1'b0);
      run_until_idle("timeout");
      compare("timeout");
      check("timeout_err_cycle", err_cyc[0], rise_q[0] + 3);
      check("timeout_req_width", fall_q[0] - rise_q[0], 4);
      last_w = 1'b0;

      // Walker aborts mid-beat, bus acks afterwards
      clear_obs();
      add_beat(1'b0, 32'h0000_7100, 3, 1'b0, 32'h5555_0001, 1'b1);
      exp_ev.delete();
      go(1'b0);
      r = 0;
      while (rise_q.size() == 0 && r < 10) begin step(); r++; end
      check("abort_beat_started", rise_q.size(), 1);
      step();
      wk_req[0] = 1'b0;
      q0.delete();
      run_until_idle("abort");
      check("abort_no_pulse", obs_ev.size(), 0);
      check("abort_idle_cycle", idle_q[0], rise_q[0] + 4);
      last_w = 1'b0;
      random_round(3);

      // Async reset in the middle of a beat
      clear_obs();
      add_beat(1'b0, 32'h0000_7200, 99, 1'b0, 32'h0, 1'b1);
      go(1'b0);
      step(); step(); step();
      check("pre_reset_in_beat", bus_req_o, 1);
      rst_n = 1'b0;
      #1;
      check("reset_mid_beat_bus_req", bus_req_o, 0);
      check("reset_mid_beat_busy", busy_o, 0);
      check("reset_mid_beat_pulses", {dmmu_ack_o, dmmu_err_o}, 0);
      do_reset();
      random_round(3);

      for (int i = 0; i < 25; i++) random_round(0);

      // Disabled watchdog keeps the beat open indefinitely
      nt_high = 0; nt_errs = 0;
      nt_req = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         step();
         if (nt_bus_req) nt_high++;
         if (nt_derr) nt_errs++;
      end
      check("no_timeout_req_held", nt_high, 1000);
      check("no_timeout_no_err", nt_errs, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
